pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter WAKE_CYC, default 2: cycles spent in WAKE after leaving SLEEP; legal range 1..15.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 ex_rd  in  5  destination register of the instruction in EX; ex_mem_read  in  1  EX instruction is a load.
REQ-006 im_wait, dm_wait  in  1 each  instruction-memory and data-memory not ready.
REQ-007 branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 wfi_ex, mret_ex  in  1 each  WFI or MRET is in EX.
REQ-009 intr_req  in  1  level external interrupt pending; mie  in  1  global interrupt enable.
REQ-010 stall_IF  out  1  freeze the whole pipeline (memory wait).
REQ-011 stall  out  1  load-use hold of PC and IF/ID; bubble into ID/EX.
REQ-012 next_pc_sel  out  1  branch redirect; flush IF/ID.
REQ-013 wfi_signal, intr_ex, intr_end_ex  out  1 each  sleep, trap-entry, trap-return indications; each flushes IF/ID.
REQ-014 flush_idex  out  1  zero ID/EX.
REQ-015 stall_cnt  out  32  saturating performance counter.

Function
REQ-016 stall_IF SHALL be im_wait|dm_wait, combinational, in every state except reset.
REQ-017 stall SHALL be ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2), gated to 0 when the state is not RUN or when branch_taken=1.
REQ-018 next_pc_sel SHALL equal branch_taken in RUN and 0 in every other state.
REQ-019 Output priority SHALL be: rst > stall_IF > FSM event (trap/return/sleep) > branch > load-use.
REQ-020 While stall_IF=1, the FSM, in_service and wake counter SHALL hold; intr_ex and intr_end_ex SHALL be 0.
REQ-021 FSM states SHALL be RUN, SLEEP, WAKE, TRAP and RET.
REQ-022 RUN->TRAP SHALL occur when intr_req & mie & !in_service & !stall_IF; this rule takes priority over wfi_ex and mret_ex.
REQ-023 RUN->RET SHALL occur on mret_ex & in_service & !stall_IF.
REQ-024 RUN->SLEEP SHALL occur on wfi_ex & !stall_IF.
REQ-025 TRAP SHALL last 1 cycle, assert intr_ex=1 and flush_idex=1, set in_service, then go to RUN.
REQ-026 RET SHALL last 1 cycle, assert intr_end_ex=1 and flush_idex=1, clear in_service, then go to RUN.
REQ-027 SLEEP SHALL assert wfi_signal=1 every cycle; on intr_req=1 (regardless of mie) it SHALL go to WAKE and load the wake counter with WAKE_CYC-1.
REQ-028 WAKE SHALL keep wfi_signal=1 and decrement the counter. At 0 it SHALL go to TRAP if mie & !in_service, else to RUN.
REQ-029 flush_idex SHALL also be 1 whenever stall=1 or next_pc_sel=1.
REQ-030 stall_cnt SHALL increment by 1 in each cycle where stall|stall_IF=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-031 mret_ex with in_service=0 SHALL be ignored (no RET, no pulse).

Reset
REQ-032 On rst: state=RUN, in_service=0, wake counter=0, stall_cnt=0.
REQ-033 During rst all 1-bit outputs SHALL be 0; the first post-reset cycle follows REQ-016..031.
REQ-034 rst asserted in any state, including mid-WAKE or TRAP, SHALL abort to RUN with no pulse emitted.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (3-bit) and the constant REG_X0=5'd0.
REQ-036 One sub-module, hazard_detect, SHALL hold the combinational load-use compare of REQ-017; the FSM and counters SHALL stay in the top module.

Verification
REQ-037 ex_mem_read=1, ex_rd=5, id_rs1=5 -> stall=1, flush_idex=1, stall_cnt +1. Repeat with ex_rd=0 -> stall=0.
REQ-038 Load-use hazard together with branch_taken=1 -> stall=0, next_pc_sel=1, flush_idex=1.
REQ-039 intr_req=1, mie=1 in RUN -> intr_ex=1 for exactly 1 cycle on the next cycle. A second intr_req while in_service=1 -> no pulse until mret_ex, which gives intr_end_ex=1 for 1 cycle.
REQ-040 wfi_ex=1 -> wfi_signal=1 from the next cycle on. Then intr_req=1 with WAKE_CYC=2, mie=1 -> 2 WAKE cycles, then intr_ex=1.
REQ-041 dm_wait=1 for 3 cycles while intr_req=1 -> stall_IF=1 for 3 cycles, no intr_ex; intr_ex follows after dm_wait drops, and stall_cnt=3.
REQ-042 rst pulsed during WAKE -> all outputs 0, state RUN, stall_cnt=0; preload stall_cnt to saturation -> it stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/interrupt controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SLEEP = 3'd1,
    WAKE  = 3'd2,
    TRAP  = 3'd3,
    RET   = 3'd4
  } state_e;

  localparam logic [4:0]  REG_X0  = 5'd0;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the EX load destination and ID sources.
// x0 never creates a hazard since it is hardwired to zero.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_X0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: memory freeze, load-use stall, branch flush, and the
// WFI / interrupt-entry / MRET sequencing FSM with a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        im_wait,
  input  logic        dm_wait,
  input  logic        branch_taken,
  input  logic        wfi_ex,
  input  logic        mret_ex,
  input  logic        intr_req,
  input  logic        mie,
  output logic        stall_IF,
  output logic        stall,
  output logic        next_pc_sel,
  output logic        wfi_signal,
  output logic        intr_ex,
  output logic        intr_end_ex,
  output logic        flush_idex,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYC - 1);

  state_e      state_q, state_d;
  logic        in_service_q, in_service_d;
  logic [3:0]  wake_cnt_q, wake_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic mem_wait;
  logic load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_wait = im_wait | dm_wait;

  // A memory wait freezes every piece of FSM state, so pending events resume intact.
  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    wake_cnt_d   = wake_cnt_q;
    if (!mem_wait) begin
      case (state_q)
        RUN: begin
          if (intr_req && mie && !in_service_q) begin
            state_d = TRAP;
          end else if (mret_ex && in_service_q) begin
            state_d = RET;
          end else if (wfi_ex) begin
            state_d = SLEEP;
          end
        end
        SLEEP: begin
          if (intr_req) begin
            state_d    = WAKE;
            wake_cnt_d = WAKE_LOAD;
          end
        end
        WAKE: begin
          if (wake_cnt_q == 4'd0) begin
            state_d = (mie && !in_service_q) ? TRAP : RUN;
          end else begin
            wake_cnt_d = wake_cnt_q - 4'd1;
          end
        end
        TRAP: begin
          in_service_d = 1'b1;
          state_d      = RUN;
        end
        RET: begin
          in_service_d = 1'b0;
          state_d      = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    if (rst) begin
      state_d      = RUN;
      in_service_d = 1'b0;
      wake_cnt_d   = 4'd0;
    end
  end

  always_comb begin
    stall_IF    = !rst && mem_wait;
    next_pc_sel = !rst && (state_q == RUN) && branch_taken;
    stall       = !rst && (state_q == RUN) && !branch_taken && load_use;
    wfi_signal  = !rst && ((state_q == SLEEP) || (state_q == WAKE));
    intr_ex     = !rst && !mem_wait && (state_q == TRAP);
    intr_end_ex = !rst && !mem_wait && (state_q == RET);
    flush_idex  = intr_ex || intr_end_ex || stall || next_pc_sel;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = 32'd0;
    end else if ((stall || stall_IF) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    in_service_q <= in_service_d;
    wake_cnt_q   <= wake_cnt_d;
    stall_cnt_q  <= stall_cnt_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: table of single-cycle hazard vectors plus hand-written
// interrupt, sleep/wake, memory-wait, reset-abort and saturation sequences.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_mem_read, im_wait, dm_wait, branch_taken;
  logic        wfi_ex, mret_ex, intr_req, mie;
  logic        stall_IF, stall, next_pc_sel, wfi_signal, intr_ex, intr_end_ex, flush_idex;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.WAKE_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .im_wait      (im_wait),
    .dm_wait      (dm_wait),
    .branch_taken (branch_taken),
    .wfi_ex       (wfi_ex),
    .mret_ex      (mret_ex),
    .intr_req     (intr_req),
    .mie          (mie),
    .stall_IF     (stall_IF),
    .stall        (stall),
    .next_pc_sel  (next_pc_sel),
    .wfi_signal   (wfi_signal),
    .intr_ex      (intr_ex),
    .intr_end_ex  (intr_end_ex),
    .flush_idex   (flush_idex),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle order: {stall_IF, stall, next_pc_sel, flush_idex, wfi_signal, intr_ex, intr_end_ex}
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       ld, br, imw, dmw;
    logic [6:0] exp;
    logic       inc;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [6:0] outs();
    return {stall_IF, stall, next_pc_sel, flush_idex, wfi_signal, intr_ex, intr_end_ex};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; ex_mem_read = 1'b0;
    im_wait = 1'b0; dm_wait = 1'b0; branch_taken = 1'b0;
    wfi_ex = 1'b0; mret_ex = 1'b0; intr_req = 1'b0; mie = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_cnt;

    vecs[0] = '{"lu_rs1",    5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0101000, 1'b1};
    vecs[1] = '{"lu_x0",     5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0};
    vecs[2] = '{"lu_rs2",    5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0101000, 1'b1};
    vecs[3] = '{"no_load",   5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0};
    vecs[4] = '{"lu_branch", 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0011000, 1'b0};
    vecs[5] = '{"branch",    5'd0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0011000, 1'b0};
    vecs[6] = '{"im_wait",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1000000, 1'b1};
    vecs[7] = '{"dm_wait",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b1000000, 1'b1};
    vecs[8] = '{"lu_miss",   5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0};
    vecs[9] = '{"lu_both",   5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0101000, 1'b1};

    // Reset: outputs forced low even with wait and hazard inputs active
    set_idle();
    rst = 1'b1;
    im_wait = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; branch_taken = 1'b1;
    tick();
    #1;
    chk("reset_outs", 32'(outs()), 32'd0);
    tick();
    chk("reset_cnt", stall_cnt, 32'd0);
    set_idle();
    rst = 1'b0;

    // Table-driven single-cycle vectors in RUN
    exp_cnt = 32'd0;
    for (int i = 0; i < 10; i++) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      ex_mem_read = vecs[i].ld; branch_taken = vecs[i].br;
      im_wait = vecs[i].imw; dm_wait = vecs[i].dmw;
      #1;
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      tick();
      exp_cnt = exp_cnt + 32'(vecs[i].inc);
      chk({vecs[i].name, "_cnt"}, stall_cnt, exp_cnt);
    end
    set_idle();

    // Interrupt entry, blocked nesting, MRET return, ignored MRET
    mie = 1'b1; intr_req = 1'b1;
    #1;
    chk("trap_pre", 32'(outs()), 32'd0);
    tick();
    chk("trap_pulse", 32'(outs()), 32'b0001010);
    tick();
    chk("nested_blk1", 32'(outs()), 32'd0);
    tick();
    chk("nested_blk2", 32'(outs()), 32'd0);
    intr_req = 1'b0; mret_ex = 1'b1;
    tick();
    mret_ex = 1'b0;
    #1;
    chk("ret_pulse", 32'(outs()), 32'b0001001);
    tick();
    chk("ret_done", 32'(outs()), 32'd0);
    mret_ex = 1'b1;
    tick();
    mret_ex = 1'b0;
    #1;
    chk("mret_ignored", 32'(outs()), 32'd0);

    // WFI -> SLEEP -> two WAKE cycles -> TRAP
    wfi_ex = 1'b1;
    tick();
    wfi_ex = 1'b0;
    #1;
    chk("sleep1", 32'(outs()), 32'b0000100);
    tick();
    chk("sleep2", 32'(outs()), 32'b0000100);
    intr_req = 1'b1;
    tick();
    chk("wake1", 32'(outs()), 32'b0000100);
    tick();
    chk("wake2", 32'(outs()), 32'b0000100);
    tick();
    chk("wake_trap", 32'(outs()), 32'b0001010);
    intr_req = 1'b0;
    tick();
    chk("wake_run", 32'(outs()), 32'd0);

    // Memory wait holds a pending interrupt for three cycles
    set_idle();
    do_reset();
    mie = 1'b1; intr_req = 1'b1; dm_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("dmw_hold%0d", i), 32'(outs()), 32'b1000000);
      tick();
    end
    dm_wait = 1'b0;
    #1;
    chk("dmw_release", 32'(outs()), 32'd0);
    chk("dmw_cnt", stall_cnt, 32'd3);
    tick();
    chk("dmw_trap", 32'(outs()), 32'b0001010);
    intr_req = 1'b0;

    // Reset during WAKE aborts cleanly
    set_idle();
    do_reset();
    wfi_ex = 1'b1;
    tick();
    wfi_ex = 1'b0; im_wait = 1'b1;
    tick();
    chk("sleep_hold_cnt", stall_cnt, 32'd1);
    im_wait = 1'b0; intr_req = 1'b1; mie = 1'b1;
    tick();
    chk("abort_in_wake", 32'(outs()), 32'b0000100);
    rst = 1'b1; im_wait = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    chk("abort_rst_outs", 32'(outs()), 32'd0);
    tick();
    set_idle();
    rst = 1'b0; mie = 1'b1;
    #1;
    chk("abort_post_outs", 32'(outs()), 32'd0);
    chk("abort_post_cnt", stall_cnt, 32'd0);
    tick();
    chk("abort_no_pulse", 32'(outs()), 32'd0);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    #1;
    chk("abort_in_run", 32'(outs()), 32'b0101000);
    set_idle();

    // Saturation of the stall counter
    im_wait = 1'b1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    tick();
    chk("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    tick();
    chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
